boot_ctrl: RTL

Boot sequencer and RAM owner-switch for the SoC. It parses a byte stream from the serial receiver (start marker, length, program words, checksum) and writes the program words into the instruction/data RAM, holding the CPU in reset while it does so. After a checksum-verified load it hands the RAM port to the CPU and releases CPU reset. It also multiplexes the single RAM write port between the loader and the CPU.

---
 rtl/boot_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/boot_ctrl.sv
// Boot sequencer: parses MAGIC/len/words/checksum from rx bytes into RAM, then hands RAM to CPU.
// Latency: word write 1 cycle after its last byte; booting falls 1 cycle after good checksum.
// Backpressure: none, a byte is consumed whenever rx_valid=1; boot_req overrides rx_valid.
//
// Ports: clk/rst_n; rx_valid/rx_data byte stream; boot_req reload pulse;
// cpu_ram_* CPU write port; ram_* muxed RAM port; booting, cpu_rst, boot_err,
// words_loaded status.
module boot_ctrl #(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 16,
    parameter int          RST_HOLD = 4,
    parameter logic [7:0]  MAGIC    = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              boot_req,
    input  logic [ADDR_W-1:0] cpu_ram_addr,
    input  logic              cpu_ram_we,
    input  logic [DATA_W-1:0] cpu_ram_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              booting,
    output logic              cpu_rst,
    output logic              boot_err,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int BPW  = DATA_W / 8;
    localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int HC_W = $clog2(RST_HOLD + 1);
    localparam int WL_W = ADDR_W + 1;

    localparam logic [2:0] S_WAIT_MAGIC = 3'd0;
    localparam logic [2:0] S_LEN        = 3'd1;
    localparam logic [2:0] S_DATA       = 3'd2;
    localparam logic [2:0] S_CSUM       = 3'd3;
    localparam logic [2:0] S_HOLD       = 3'd4;
    localparam logic [2:0] S_RUN        = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [BC_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [7:0]        csum_q, csum_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [WL_W-1:0]   words_q, words_d;
    logic              booting_q, booting_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              err_q, err_d;
    logic              ld_we_q, ld_we_d;
    logic [ADDR_W-1:0] ld_addr_q, ld_addr_d;
    logic [DATA_W-1:0] ld_wdata_q, ld_wdata_d;

    // MSB-first assembly: earlier bytes shift toward the top of the word.
    logic [DATA_W-1:0] word_next;
    assign word_next = (word_q << 8) | DATA_W'(rx_data);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        csum_d     = csum_q;
        hold_d     = hold_q;
        words_d    = words_q;
        booting_d  = booting_q;
        cpu_rst_d  = cpu_rst_q;
        err_d      = err_q;
        ld_we_d    = 1'b0;
        ld_addr_d  = ld_addr_q;
        ld_wdata_d = ld_wdata_q;

        if (boot_req) begin
            // Reload wins over any byte this cycle; a write that would land
            // next cycle is dropped because ld_we_d stays at its default 0.
            state_d    = S_WAIT_MAGIC;
            booting_d  = 1'b1;
            cpu_rst_d  = 1'b1;
            words_d    = '0;
            byte_cnt_d = '0;
            csum_d     = '0;
            hold_d     = '0;
        end else begin
            case (state_q)
                S_WAIT_MAGIC: begin
                    if (rx_valid && rx_data == MAGIC) begin
                        state_d    = S_LEN;
                        err_d      = 1'b0;
                        words_d    = '0;
                        csum_d     = '0;
                        byte_cnt_d = '0;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        if (rx_data == 8'd0) begin
                            err_d   = 1'b1;
                            state_d = S_WAIT_MAGIC;
                        end else begin
                            len_d   = rx_data;
                            state_d = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (rx_valid) begin
                        csum_d = csum_q + rx_data;
                        word_d = word_next;
                        if (byte_cnt_q == BC_W'(BPW - 1)) begin
                            byte_cnt_d = '0;
                            ld_we_d    = 1'b1;
                            ld_addr_d  = words_q[ADDR_W-1:0];
                            ld_wdata_d = word_next;
                            words_d    = words_q + WL_W'(1);
                            if (words_q + WL_W'(1) == WL_W'(len_q)) begin
                                state_d = S_CSUM;
                            end
                        end else begin
                            byte_cnt_d = byte_cnt_q + BC_W'(1);
                        end
                    end
                end
                S_CSUM: begin
                    if (rx_valid) begin
                        if (rx_data == csum_q) begin
                            state_d   = S_HOLD;
                            booting_d = 1'b0;
                            hold_d    = HC_W'(RST_HOLD - 1);
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_WAIT_MAGIC;
                        end
                    end
                end
                S_HOLD: begin
                    // Entered with RST_HOLD-1 so cpu_rst stays high exactly RST_HOLD cycles.
                    if (hold_q == '0) begin
                        cpu_rst_d = 1'b0;
                        state_d   = S_RUN;
                    end else begin
                        hold_d = hold_q - HC_W'(1);
                    end
                end
                S_RUN: begin
                end
                default: begin
                    state_d = S_WAIT_MAGIC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_WAIT_MAGIC;
            len_q      <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            hold_q     <= '0;
            words_q    <= '0;
            booting_q  <= 1'b1;
            cpu_rst_q  <= 1'b1;
            err_q      <= 1'b0;
            ld_we_q    <= 1'b0;
            ld_addr_q  <= '0;
            ld_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            hold_q     <= hold_d;
            words_q    <= words_d;
            booting_q  <= booting_d;
            cpu_rst_q  <= cpu_rst_d;
            err_q      <= err_d;
            ld_we_q    <= ld_we_d;
            ld_addr_q  <= ld_addr_d;
            ld_wdata_q <= ld_wdata_d;
        end
    end

    // Loader drives registered values while it owns RAM; CPU path is pure pass-through.
    assign ram_addr     = booting_q ? ld_addr_q  : cpu_ram_addr;
    assign ram_we       = booting_q ? ld_we_q    : cpu_ram_we;
    assign ram_wdata    = booting_q ? ld_wdata_q : cpu_ram_wdata;
    assign booting      = booting_q;
    assign cpu_rst      = cpu_rst_q;
    assign boot_err     = err_q;
    assign words_loaded = words_q;

endmodule
